// File: rtl/ifetch_ctrl_pkg.sv
// Shared widths, reset PC and fetch FSM state type for the instruction-fetch controller.
package ifetch_ctrl_pkg;

    localparam int unsigned WORD_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH   = 32;
    localparam int unsigned PC_STEP_BYTES = 4;
    localparam logic [WORD_WIDTH-1:0] PC_BASE = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifetch_slot.sv
// IF/ID output register with a one-entry hold buffer for responses that arrive while decode is stalled.
module ifetch_slot #(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_resp,
    input  logic [IW-1:0] resp_data,
    input  logic [AW-1:0] resp_pc,
    input  logic          capture,
    input  logic          load_hold,
    input  logic          consume,
    input  logic          flush,
    output logic          instr_valid,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc
);

    logic          hold_valid;
    logic [IW-1:0] hold_data;
    logic [AW-1:0] hold_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            hold_pc     <= '0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            hold_valid  <= 1'b0;
        end else begin
            if (load_resp) begin
                instr_valid <= 1'b1;
                instr       <= resp_data;
                instr_pc    <= resp_pc;
            end else if (load_hold && hold_valid) begin
                instr_valid <= 1'b1;
                instr       <= hold_data;
                instr_pc    <= hold_pc;
                hold_valid  <= 1'b0;
            end else if (consume) begin
                instr_valid <= 1'b0;
            end
            if (capture) begin
                hold_valid <= 1'b1;
                hold_data  <= resp_data;
                hold_pc    <= resp_pc;
            end
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: one outstanding imem request, decode-stall hold buffer, redirect flush with stale-response drop.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int unsigned AW      = WORD_WIDTH,
    parameter int unsigned IW      = INSTR_WIDTH,
    parameter int unsigned PC_STEP = PC_STEP_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] npc,
    output logic          stallF,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_target,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_resp_valid,
    input  logic [IW-1:0] imem_resp_data,
    output logic          instr_valid,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          stallD
);

    fetch_state_t state_q, state_d;
    logic slot_free, consume;
    logic deliver_resp, deliver_hold, capture;

    assign slot_free = !instr_valid || !stallD;
    assign consume   = instr_valid && !stallD;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_REQ;
        else     state_q <= state_d;
    end

    // A redirect wins over everything; an accepted or outstanding old request must be dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (imem_req_ready) state_d = redirect_valid ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_valid)       state_d = imem_resp_valid ? ST_REQ : ST_DROP;
                else if (imem_resp_valid) state_d = slot_free ? ST_REQ : ST_HOLD;
            end
            ST_HOLD: begin
                if (redirect_valid || slot_free) state_d = ST_REQ;
            end
            ST_DROP: begin
                if (imem_resp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == ST_REQ) && !rst;
        imem_req_addr  = pc;
        deliver_resp   = (state_q == ST_WAIT) && imem_resp_valid && slot_free && !redirect_valid;
        capture        = (state_q == ST_WAIT) && imem_resp_valid && !slot_free && !redirect_valid;
        deliver_hold   = (state_q == ST_HOLD) && slot_free && !redirect_valid;
        stallF         = !(redirect_valid || deliver_resp || deliver_hold);
        npc            = redirect_valid ? redirect_target : pc + AW'(PC_STEP);
    end

    ifetch_slot #(
        .AW (AW),
        .IW (IW)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_resp   (deliver_resp),
        .resp_data   (imem_resp_data),
        .resp_pc     (pc),
        .capture     (capture),
        .load_hold   (deliver_hold),
        .consume     (consume),
        .flush       (redirect_valid),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed cycle table, wrap/reset sequences, then random traffic against a fetch-stream model.
module tb_ifetch_ctrl;
    import ifetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] npc;
    logic        stallF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stallD = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch_ctrl #(.AW(32), .IW(32), .PC_STEP(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .npc             (npc),
        .stallF          (stallF),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .stallD          (stallD)
    );

    always #5 clk = ~clk;

    // PC register owned by the bench
    always @(posedge clk) begin
        if (rst)          pc <= PC_BASE;
        else if (!stallF) pc <= npc;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdy, rsp, sd, rd;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr, e_npc;
        logic        e_stallF, e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, rsp, sd, rd, input logic [31:0] tgt,
                                input logic er, input logic [31:0] ea, en,
                                input logic es, ei, input logic [31:0] eipc);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.sd = sd; v.rd = rd; v.tgt = tgt;
        v.e_req = er; v.e_addr = ea; v.e_npc = en;
        v.e_stallF = es; v.e_iv = ei; v.e_ipc = eipc;
        return v;
    endfunction

    logic [31:0] last_addr = '0;

    task automatic drive(input logic r, rdy, rsp, sd, rd, input logic [31:0] tgt);
        @(negedge clk);
        rst             = r;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = mem_word(last_addr);
        stallD          = sd;
        redirect_valid  = rd;
        redirect_target = tgt;
        #1;
    endtask

    task automatic note_accept();
        if (imem_req_valid && imem_req_ready) last_addr = imem_req_addr;
    endtask

    vec_t vt[20];

    // random-phase memory and stream model
    logic        m_busy;
    logic [31:0] m_addr;
    int unsigned m_cnt;
    logic [31:0] exp_pc;
    int          consumed;
    int          idle;

    initial begin
        vt[0]  = mk(1,0,0,0,32'h0,    1,32'h3000,32'h3004, 1,0,32'h0);
        vt[1]  = mk(1,1,0,0,32'h0,    0,32'h3000,32'h3004, 0,0,32'h0);
        vt[2]  = mk(1,0,0,0,32'h0,    1,32'h3004,32'h3008, 1,1,32'h3000);
        vt[3]  = mk(1,1,0,0,32'h0,    0,32'h3004,32'h3008, 0,0,32'h3000);
        vt[4]  = mk(1,0,1,0,32'h0,    1,32'h3008,32'h300C, 1,1,32'h3004);
        vt[5]  = mk(1,1,1,0,32'h0,    0,32'h3008,32'h300C, 1,1,32'h3004);
        vt[6]  = mk(1,0,1,0,32'h0,    0,32'h3008,32'h300C, 1,1,32'h3004);
        vt[7]  = mk(1,0,0,0,32'h0,    0,32'h3008,32'h300C, 0,1,32'h3004);
        vt[8]  = mk(1,0,1,0,32'h0,    1,32'h300C,32'h3010, 1,1,32'h3008);
        vt[9]  = mk(1,0,1,1,32'h4000, 0,32'h300C,32'h4000, 0,1,32'h3008);
        vt[10] = mk(1,0,0,0,32'h0,    0,32'h4000,32'h4004, 1,0,32'h3008);
        vt[11] = mk(1,0,0,0,32'h0,    0,32'h4000,32'h4004, 1,0,32'h3008);
        vt[12] = mk(1,1,0,0,32'h0,    0,32'h4000,32'h4004, 1,0,32'h3008);
        vt[13] = mk(0,0,0,0,32'h0,    1,32'h4000,32'h4004, 1,0,32'h3008);
        vt[14] = mk(0,0,0,1,32'h5000, 1,32'h4000,32'h5000, 0,0,32'h3008);
        vt[15] = mk(1,0,0,0,32'h0,    1,32'h5000,32'h5004, 1,0,32'h3008);
        vt[16] = mk(1,1,0,1,32'h6000, 0,32'h5000,32'h6000, 0,0,32'h3008);
        vt[17] = mk(1,0,0,0,32'h0,    1,32'h6000,32'h6004, 1,0,32'h3008);
        vt[18] = mk(1,1,0,0,32'h0,    0,32'h6000,32'h6004, 0,0,32'h3008);
        vt[19] = mk(0,0,0,0,32'h0,    1,32'h6004,32'h6008, 1,1,32'h6000);

        // reset
        drive(1,0,0,0,0,'0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        drive(1,0,0,0,0,'0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);

        // directed table: sequential run, decode stall/hold, redirects in WAIT/REQ
        for (int i = 0; i < 20; i++) begin
            drive(0, vt[i].rdy, vt[i].rsp, vt[i].sd, vt[i].rd, vt[i].tgt);
            chk($sformatf("t%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vt[i].e_req});
            chk($sformatf("t%0d_req_addr", i),  imem_req_addr, vt[i].e_addr);
            chk($sformatf("t%0d_npc", i),       npc, vt[i].e_npc);
            chk($sformatf("t%0d_stallF", i),    {31'b0, stallF}, {31'b0, vt[i].e_stallF});
            chk($sformatf("t%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].e_iv});
            chk($sformatf("t%0d_instr_pc", i),  instr_pc, vt[i].e_ipc);
            if (vt[i].e_iv) chk($sformatf("t%0d_instr", i), instr, mem_word(vt[i].e_ipc));
            note_accept();
        end

        // wrap at top of address space
        drive(0,0,0,0,1,32'hFFFF_FFFC);
        chk("wrap_redirect_npc", npc, 32'hFFFF_FFFC);
        note_accept();
        drive(0,1,0,0,0,'0);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'h0000_0000);
        note_accept();
        drive(0,0,1,1,0,'0);
        chk("wrap_deliver_stallF", {31'b0, stallF}, 32'd0);
        chk("wrap_deliver_npc", npc, 32'h0000_0000);
        note_accept();
        drive(0,0,0,1,0,'0);
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, mem_word(32'hFFFF_FFFC));

        // reset while WAIT with a held instruction
        drive(0,1,0,1,0,'0);
        chk("wr_iv_before", {31'b0, instr_valid}, 32'd1);
        drive(1,0,0,1,0,'0);
        chk("wr_req_valid_in_rst", {31'b0, imem_req_valid}, 32'd0);
        drive(0,0,0,0,0,'0);
        chk("wr_iv_after", {31'b0, instr_valid}, 32'd0);
        chk("wr_req_valid_after", {31'b0, imem_req_valid}, 32'd1);
        chk("wr_req_addr_after", imem_req_addr, PC_BASE);

        // random traffic against the expected fetch stream
        drive(1,0,0,0,0,'0);
        drive(1,0,0,0,0,'0);
        m_busy = 1'b0; m_addr = '0; m_cnt = 0;
        exp_pc = PC_BASE; consumed = 0; idle = 0;
        for (int c = 0; c < 4000; c++) begin
            logic rdy, rsp, sd, rd;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            sd  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            rsp = m_busy && (m_cnt == 0);
            if (m_busy && m_cnt != 0) m_cnt--;
            last_addr = m_addr;
            drive(0, rdy, rsp, sd, rd, tgt);

            chk("rnd_npc", npc, rd ? tgt : pc + 32'd4);
            if (imem_req_valid) chk("rnd_req_addr", imem_req_addr, pc);
            if (instr_valid && !sd && !rd) begin
                chk("rnd_instr_pc", instr_pc, exp_pc);
                chk("rnd_instr", instr, mem_word(instr_pc));
                exp_pc = instr_pc + 32'd4;
                consumed++;
                idle = 0;
            end else begin
                idle++;
            end
            if (rd) exp_pc = tgt;
            if (rsp) m_busy = 1'b0;
            if (imem_req_valid && rdy) begin
                chk("rnd_single_outstanding", {31'b0, m_busy}, 32'd0);
                m_busy = 1'b1;
                m_addr = imem_req_addr;
                m_cnt  = $urandom_range(0, 3);
            end
            if (idle > 200) begin
                chk("rnd_progress_timeout", idle, 0);
                break;
            end
        end
        chk("rnd_progress", {31'b0, consumed > 200}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
